pio_edge_capture_in: RTL and testbench
======================================

Name: pio_edge_capture_in

Overview:
- Parametrised Avalon-MM slave input PIO for switches, toggles and pushbuttons on the NIOS system bus.
- Generalises the fixed-width input PIO with:
  - configurable width
  - configurable synchroniser depth
  - selectable edge polarity
  - per-bit write-1-to-clear edge capture
  - optional per-bit debounce
- Drives a single level IRQ to the NIOS interrupt controller.

Parameters:
- WIDTH, 18: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops ahead of edge logic, 2..4.
- EDGE_TYPE, 2: 0 = rising, 1 = falling, 2 = any edge.
- DEBOUNCE_CYCLES, 50000: cycles an input must be stable before it is accepted. Used only with the optional feature. Range 2..2^20.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: all synchroniser flops, accepted value, previous accepted value, irq_mask, edge_capture and readdata are 0. irq is therefore 0.
- Input path:
  - in_port → SYNC_STAGES flop chain → "raw" → acceptance stage → "accepted" → one delay flop → "prev".
  - Without debounce, accepted = raw registered. Total input-to-accepted latency is SYNC_STAGES+1 cycles.
- Edge detect, per bit:
  - rising = accepted & ~prev
  - falling = ~accepted & prev
  - any = accepted ^ prev
- Register map (read):
  - 0: accepted value
  - 1: 0
  - 2: irq_mask
  - 3: edge_capture
  - Upper 32-WIDTH bits read 0.
- Read timing: readdata is registered every clk from the address mux regardless of chipselect, giving 1-cycle read latency. No wait states.
- Register map (write):
  - Writes occur when chipselect & ~write_n.
  - Address 2 loads irq_mask ← writedata[WIDTH-1:0].
  - Address 3 is write-1-to-clear: bit i clears where writedata[i]=1; bits written 0 are untouched.
  - Addresses 0 and 1 ignore writes.
- edge_capture[i]: set on edge_detect[i]; cleared by W1C. If the set and the clear coincide in the same cycle, set wins, so no event is lost.
- irq: combinational |(edge_capture & irq_mask). Deasserts in the cycle after the clearing write.
- Simultaneous edges on several bits set all corresponding bits in the same cycle.
- Reset mid-operation clears everything immediately, including any debounce counts. After release, edges are not reported until the first transition of accepted; accepted starts from 0.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- When defined, each bit gets a debounce unit between raw and accepted:
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - While raw[i] == accepted[i], the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the count reaches DEBOUNCE_CYCLES-1 and raw still differs, accepted[i] ← raw[i] and the counter returns to 0.
  - Any return of raw to accepted before then resets the counter; a glitch shorter than DEBOUNCE_CYCLES is never reported.
  - Latency from a stable input change to accepted is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- When not defined: no counters are instantiated, accepted = raw registered, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Shared package pio_pkg holds:
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2
  - register address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3
- One natural sub-module: pio_debounce_bit. It is a single-bit counter/acceptance unit instantiated WIDTH times in a generate loop, present only under PIO_DEBOUNCE_EN.

Test Plan:
- Reset, then read addresses 0..3 → readdata = 0 on the cycle after each read, and irq=0.
- EDGE_TYPE=2, WIDTH=18:
  - Drive in_port=0x00005.
  - Wait SYNC_STAGES+2 cycles, read address 3 → 0x00005.
  - Read address 0 → 0x00005.
  - irq stays 0 while mask=0.
- Write mask=0x00001 → irq=1. Write address 3 with 0x00001 → irq=0 next cycle, and edge_capture reads 0x00004.
- EDGE_TYPE=0, in_port bit3 toggled 0→1→0:
  - Only one capture is seen (bit3 set once).
  - A falling-only toggle sets nothing.
- Force the edge on bit1 in the same cycle as a W1C of 0x00002 → bit1 remains set.
- PIO_DEBOUNCE_EN with DEBOUNCE_CYCLES=8:
  - A 5-cycle pulse on bit0 → no capture, accepted stays 0.
  - A 20-cycle level → accepted[0]=1 exactly SYNC_STAGES+8 cycles after the change, and edge_capture[0]=1.

Source files
------------

// File: rtl/pio_pkg.sv
// pio_pkg: shared constants and helpers for the edge-capturing input PIO.
package pio_pkg;

  // Edge polarity selection
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  // Per-bit edge detect between the current and previous accepted values.
  function automatic logic [31:0] edge_detect(int unsigned edge_type, logic [31:0] cur,
                                              logic [31:0] prev);
    case (edge_type)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      default:      return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: single-bit debounce. The raw input must differ from the accepted
// value for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
module pio_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic accepted_o
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            acc_q, acc_d;

  // Count while raw disagrees; any agreement restarts the count from zero.
  always_comb begin
    cnt_d = '0;
    acc_d = acc_q;
    if (raw_i != acc_q) begin
      if (cnt_q == CntMax) begin
        acc_d = raw_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and accepted-value state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign accepted_o = acc_q;

endmodule

// File: rtl/pio_edge_capture_in.sv
// pio_edge_capture_in: Avalon-MM slave input PIO with configurable synchroniser, edge
// polarity, write-1-to-clear edge capture and a level IRQ.
// Define PIO_DEBOUNCE_EN to insert a per-bit debounce unit ahead of the accepted value.
module pio_edge_capture_in
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned EDGE_TYPE       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] accepted;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  // Upper write data bits are ignored when WIDTH < 32
  assign unused_wdata = ^writedata;

  // Metastability synchroniser; stage 0 samples the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw_i     (raw[i]),
      .accepted_o(accepted[i])
    );
  end
`else
  // Acceptance stage: plain register of the synchronised value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accepted <= '0;
    end else begin
      accepted <= raw;
    end
  end
`endif

  assign edge_det = WIDTH'(edge_detect(EDGE_TYPE, 32'(accepted), 32'(prev_q)));
  assign wr_en    = chipselect & ~write_n;

  // Register writes; a new edge wins over a simultaneous W1C of the same bit
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr_mask   = '0;
    if (wr_en && (address == ADDR_IRQ_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE_CAP)) begin
      clr_mask = writedata[WIDTH-1:0];
    end
    edge_capture_d = (edge_capture_q & ~clr_mask) | edge_det;
  end

  // Read mux, sampled every cycle irrespective of chipselect
  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = accepted;
      ADDR_RSVD:     rd_mux            = '0;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_capture_q;
    endcase
  end

  // Edge history, control registers and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q         <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      readdata       <= '0;
    end else begin
      prev_q         <= accepted;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      readdata       <= rd_mux;
    end
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// tb_pio_edge_capture_in: three PIO instances (any/rising/falling edge, varied sync depth)
// share one bus; a reference model predicts read data and irq, a monitor compares.
module tb_pio_edge_capture_in;

  localparam int W  = 18;
  localparam int NI = 3;
  localparam int D  = 8;

  typedef logic [NI-1:0][31:0] rd_vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_o [NI];
  logic [NI-1:0] irq_o;

  int checks = 0;
  int errors = 0;

  logic    rd_req;
  bit      rd_vld;
  rd_vec_t exp_q[$];

  logic [W-1:0] hist[$];
  logic [W-1:0] m_acc [NI];
  logic [W-1:0] m_prev[NI];
  logic [W-1:0] m_ec  [NI];
  logic [W-1:0] m_mask[NI];

  always #5 clk = ~clk;

  pio_edge_capture_in #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(D)
  ) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd_o[0]),
    .irq(irq_o[0])
  );

  pio_edge_capture_in #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(D)
  ) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd_o[1]),
    .irq(irq_o[1])
  );

  pio_edge_capture_in #(
    .WIDTH(W), .SYNC_STAGES(3), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(D)
  ) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd_o[2]),
    .irq(irq_o[2])
  );

  function automatic int sync_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  // Cycles from an input change (sampled at an edge) until accepted shows it
  function automatic int acc_lat(int s);
`ifdef PIO_DEBOUNCE_EN
    return s + D;
`else
    return s + 1;
`endif
  endfunction

  // Input sampled n clock edges ago (0 = this edge); zero before reset release
  function automatic logic [W-1:0] hist_at(int n);
    if (n < hist.size()) return hist[n];
    return '0;
  endfunction

  // Accepted value after this edge: delayed input, optionally requiring it to hold
  // a new value for D consecutive synchronised samples.
  function automatic logic [W-1:0] acc_next(int s, logic [W-1:0] cur);
`ifdef PIO_DEBOUNCE_EN
    logic [W-1:0] r;
    logic [W-1:0] h;
    bit           held;
    r = cur;
    for (int b = 0; b < W; b++) begin
      held = 1'b1;
      for (int j = 1; j <= D; j++) begin
        h = hist_at(s - 1 + j);
        if (h[b] == cur[b]) held = 1'b0;
      end
      if (held) r[b] = ~cur[b];
    end
    return r;
`else
    return hist_at(s);
`endif
  endfunction

  function automatic logic [W-1:0] edges(int i, logic [W-1:0] cur, logic [W-1:0] prev);
    logic [W-1:0] e;
    e = '0;
    for (int b = 0; b < W; b++) begin
      if (i == 1)      e[b] = cur[b] && !prev[b];
      else if (i == 2) e[b] = !cur[b] && prev[b];
      else             e[b] = cur[b] != prev[b];
    end
    return e;
  endfunction

  // Reference model: advances one clock; pushes expected read data for requested reads
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int i = 0; i < NI; i++) begin
        m_acc[i] = '0; m_prev[i] = '0; m_ec[i] = '0; m_mask[i] = '0;
      end
      hist.delete();
      exp_q.delete();
      rd_vld = 1'b0;
    end else begin : step
      rd_vec_t      e;
      logic [W-1:0] clr;
      bit           wr;
      for (int i = 0; i < NI; i++) begin
        case (address)
          2'd0:    e[i] = 32'(m_acc[i]);
          2'd2:    e[i] = 32'(m_mask[i]);
          2'd3:    e[i] = 32'(m_ec[i]);
          default: e[i] = 32'd0;
        endcase
      end
      if (rd_req) exp_q.push_back(e);
      rd_vld = rd_req;
      hist.push_front(in_port);
      if (hist.size() > 64) void'(hist.pop_back());
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int i = 0; i < NI; i++) begin
        m_ec[i] = (m_ec[i] & ~clr) | edges(i, m_acc[i], m_prev[i]);
        if (wr && address == 2'd2) m_mask[i] = writedata[W-1:0];
        m_prev[i] = m_acc[i];
        m_acc[i]  = acc_next(sync_of(i), m_acc[i]);
      end
    end
  end

  // Monitor: compare read data when a read response is due, and irq every cycle
  initial forever begin
    @(negedge clk);
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_underflow: read response with no expected entry");
      end else begin : cmp
        rd_vec_t e;
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (rd_o[i] !== e[i]) begin
            errors++;
            $display("FAIL readdata inst%0d @%0t: got %08h want %08h", i, $time, rd_o[i], e[i]);
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (irq_o[i] !== |(m_ec[i] & m_mask[i])) begin
        errors++;
        $display("FAIL irq inst%0d @%0t: got %b want %b", i, $time, irq_o[i],
                 |(m_ec[i] & m_mask[i]));
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(logic [1:0] a);
    address    = a;
    chipselect = 1'($urandom_range(0, 1));
    write_n    = 1'b1;
    rd_req     = 1'b1;
    @(negedge clk);
    rd_req     = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Write strobe without chipselect must have no effect
  task automatic dead_wr();
    address    = 2'($urandom_range(2, 3));
    writedata  = '1;
    chipselect = 1'b0;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0; rd_req = 1'b0;
    idle(3);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a));

    // Two-bit edge, capture and data readback, irq masked
    in_port = W'(5);
    idle(acc_lat(2) + 1);
    rd(2'd3);
    rd(2'd0);
    idle(4);

    // Unmask bit0, then clear it by W1C
    wr(2'd2, 32'h1);
    rd(2'd3);
    wr(2'd3, 32'h1);
    rd(2'd3);
    rd(2'd2);

    // Bit3 pulse: captured once on rising, once on falling, twice-as-one on any
    wr(2'd3, '1);
    in_port = in_port | W'(8);
    idle(25);
    rd(2'd3);
    in_port = in_port & ~W'(8);
    idle(25);
    rd(2'd3);

    // Edge on bit1 coinciding with W1C of bit1
    in_port = '0;
    idle(25);
    wr(2'd3, '1);
    in_port = W'(2);
    idle(acc_lat(2));
    wr(2'd3, 32'h2);
    rd(2'd3);
    rd(2'd3);

    // Short pulse then a long level on bit0, read data every cycle
    in_port = '0;
    idle(25);
    wr(2'd3, '1);
    in_port = W'(1);
    repeat (5) rd(2'd0);
    in_port = '0;
    repeat (15) rd(2'd0);
    in_port = W'(1);
    repeat (20) rd(2'd0);
    repeat (4) rd(2'd3);

    // Randomised traffic with one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      int r;
      if ($urandom_range(0, 9) == 0) in_port = in_port ^ (W'(1) << $urandom_range(0, W - 1));
      if ($urandom_range(0, 49) == 0) in_port = W'($urandom);
      if (n == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) rd(2'(a));
      end
      r = $urandom_range(0, 99);
      if (r < 60)      rd(2'($urandom_range(0, 3)));
      else if (r < 70) wr(2'd2, $urandom);
      else if (r < 85) wr(2'd3, $urandom);
      else if (r < 90) wr(2'($urandom_range(0, 1)), $urandom);
      else if (r < 95) dead_wr();
      else             idle(1);
    end

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected reads left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
